// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped I/O controller: register word
// offsets relative to IO_BASE and the read-data source select encoding.
package mmio_pkg;

    localparam logic [31:0] MMIO_SW       = 32'd0;
    localparam logic [31:0] MMIO_LED      = 32'd1;
    localparam logic [31:0] MMIO_KEY_STAT = 32'd2;
    localparam logic [31:0] MMIO_KEY_DATA = 32'd3;
    localparam logic [31:0] MMIO_TONE     = 32'd4;
    localparam logic [31:0] MMIO_LAST     = 32'd4;

    // Which source drives q_dmem in the cycle after a load
    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_IO,
        SEL_ZERO
    } mmio_sel_t;

endpackage

// File: rtl/mmio_controller_key_fifo.sv
// Circular scancode FIFO with a separate occupancy count and a sticky
// overflow flag. Only elaborated when MMIO_KEY_FIFO_EN is defined, so the
// default build carries no unused module.
`ifdef MMIO_KEY_FIFO_EN
module key_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign overflow = ovf_q;
    assign dout     = mem_q[rd_ptr_q];

    // Pop needs data; push while full is accepted only if a pop frees a slot
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) count_d = count_q + CW'(1);
        if (do_pop && !do_push) count_d = count_q - CW'(1);
        // A drop in the same cycle as a status read must not be lost
        ovf_d = ovf_q;
        if (clr_ovf)                    ovf_d = 1'b0;
        if (push && full && !do_pop)    ovf_d = 1'b1;
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
    end

    // Pointer, count and flag state
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage, no reset needed since empty gates reads
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule
`endif

// File: rtl/mmio_controller.sv
// Memory-mapped I/O controller: routes processor data accesses to RAM or to
// the SW / LED / KEY_STAT / KEY_DATA / TONE registers, returning load data
// with one cycle of latency. Define MMIO_KEY_FIFO_EN to build the PS/2
// scancode FIFO; without it KEY_STAT reads as empty and KEY_DATA as zero.
module mmio_controller
    import mmio_pkg::*;
#(
    parameter int unsigned KEY_DEPTH = 8,
    parameter int unsigned IO_BASE   = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    input  logic        rden,
    output logic [31:0] q_dmem,
    output logic [11:0] ram_addr,
    output logic        ram_wEn,
    output logic [31:0] ram_dataIn,
    input  logic [31:0] ram_dataOut,
    input  logic [15:0] SW,
    output logic [15:0] LED,
    output logic [7:0]  tone,
    input  logic        key_valid,
    input  logic [7:0]  key_code
);

    localparam logic [31:0] IO_BASE_W = 32'(IO_BASE);
    localparam int unsigned CW        = $clog2(KEY_DEPTH) + 1;

    logic [15:0] sw_m_q, sw_m_d;
    logic [15:0] sw_sync_q, sw_sync_d;
    logic [15:0] led_q, led_d;
    logic [7:0]  tone_q, tone_d;
    mmio_sel_t   sel_q, sel_d;
    logic [31:0] rd_q, rd_d;

    logic        is_ram, is_io, rd_access;
    logic [31:0] offset;
    logic        key_pop, key_clr_ovf;
    logic [CW-1:0] key_count;
    logic        key_empty, key_ovf;
    logic [7:0]  key_dout;
    logic [31:0] key_stat;

    assign ram_addr   = address_dmem[11:0];
    assign ram_dataIn = data;
    assign ram_wEn    = wren & is_ram;
    assign LED        = led_q;
    assign tone       = tone_q;

    // Address decode; a simultaneous store wins and suppresses the load
    always_comb begin
        is_ram      = (address_dmem < IO_BASE_W);
        offset      = address_dmem - IO_BASE_W;
        is_io       = !is_ram && (offset <= MMIO_LAST);
        rd_access   = rden & ~wren;
        key_pop     = rd_access & is_io & (offset == MMIO_KEY_DATA);
        key_clr_ovf = rd_access & is_io & (offset == MMIO_KEY_STAT);
    end

`ifdef MMIO_KEY_FIFO_EN
    logic key_full;
    logic unused_key_full;

    key_fifo #(
        .DEPTH(KEY_DEPTH),
        .WIDTH(8)
    ) u_key_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (key_valid),
        .din      (key_code),
        .pop      (key_pop),
        .dout     (key_dout),
        .count    (key_count),
        .empty    (key_empty),
        .full     (key_full),
        .overflow (key_ovf),
        .clr_ovf  (key_clr_ovf)
    );

    assign unused_key_full = key_full;
`else
    logic unused_key;

    assign key_count  = '0;
    assign key_empty  = 1'b1;
    assign key_ovf    = 1'b0;
    assign key_dout   = '0;
    assign unused_key = ^{key_valid, key_code, key_pop, key_clr_ovf};
`endif

    // KEY_STAT word: {..0, overflow, empty, count}
    always_comb begin
        key_stat         = '0;
        key_stat[CW-1:0] = key_count;
        key_stat[CW]     = key_empty;
        key_stat[CW+1]   = key_ovf;
    end

    // Next-state for synchronizer, writable registers and the read pipeline
    always_comb begin
        sw_m_d    = SW;
        sw_sync_d = sw_m_q;
        led_d     = led_q;
        tone_d    = tone_q;
        if (wren && is_io && offset == MMIO_LED)  led_d  = data[15:0];
        if (wren && is_io && offset == MMIO_TONE) tone_d = data[7:0];

        sel_d = SEL_ZERO;
        rd_d  = '0;
        if (rd_access) begin
            if (is_ram) begin
                sel_d = SEL_RAM;
            end else if (is_io) begin
                sel_d = SEL_IO;
                case (offset)
                    MMIO_SW:       rd_d = {16'b0, sw_sync_q};
                    MMIO_LED:      rd_d = {16'b0, led_q};
                    MMIO_KEY_STAT: rd_d = key_stat;
                    MMIO_KEY_DATA: rd_d = key_empty ? '0 : {24'b0, key_dout};
                    MMIO_TONE:     rd_d = {24'b0, tone_q};
                    default:       rd_d = '0;
                endcase
            end
        end
    end

    // Register update with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_m_q    <= '0;
            sw_sync_q <= '0;
            led_q     <= '0;
            tone_q    <= '0;
            sel_q     <= SEL_ZERO;
            rd_q      <= '0;
        end else begin
            sw_m_q    <= sw_m_d;
            sw_sync_q <= sw_sync_d;
            led_q     <= led_d;
            tone_q    <= tone_d;
            sel_q     <= sel_d;
            rd_q      <= rd_d;
        end
    end

    // Load data mux; RAM data already arrives one cycle late
    always_comb begin
        case (sel_q)
            SEL_RAM: q_dmem = ram_dataOut;
            SEL_IO:  q_dmem = rd_q;
            default: q_dmem = '0;
        endcase
    end

endmodule

// File: doc/mmio_controller.md
# mmio_controller

Memory-mapped I/O controller between the processor's data-memory port and the board peripherals. Decodes each data access and routes it to data RAM, the switch input register, the LED register, the audio tone register or a PS/2 scancode FIFO. Returns read data with the same one-cycle latency as the synchronous RAM. Sits in the top-level wrapper between `processor` and `RAM` / `AudioController`, replacing the ad hoc address compares there.

## Interface

Parameters:
- `KEY_DEPTH`, default 8: scancode FIFO depth. Must be a power of two, ≥ 2.
- `IO_BASE`, default 4096: first I/O word address. Addresses below it go to RAM.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: system clock; every register updates on its posedge.
- `reset` in 1: synchronous, active-high reset.
- `address_dmem` in 32: processor data address.
- `data` in 32: processor store data.
- `wren` in 1: store strobe.
- `rden` in 1: load strobe. High for exactly the cycles the MEM stage holds a load.
- `q_dmem` out 32: load data to the processor.
- `ram_addr` out 12: `address_dmem[11:0]`.
- `ram_wEn` out 1: RAM write enable.
- `ram_dataIn` out 32: equals `data`.
- `ram_dataOut` in 32: RAM read data (already one cycle late).
- `SW` in 16: raw board switches (asynchronous).
- `LED` out 16: LED register.
- `tone` out 8: audio tone select, sent to the audio controller.
- `key_valid` in 1: one-cycle pulse from the PS/2 receiver.
- `key_code` in 8: scancode, qualified by `key_valid`.

## Operation

Address map (word addresses):
- IO_BASE+0 `SW`: read only. Returns `{16'b0, sw_sync}`.
- IO_BASE+1 `LED`: read/write. Stores `data[15:0]`.
- IO_BASE+2 `KEY_STAT`: read only. Returns `{..0, overflow, empty, count}`; `count` is log2(KEY_DEPTH)+1 bits. A read clears `overflow`.
- IO_BASE+3 `KEY_DATA`: read pops the FIFO. Returns `{24'b0, code}`, or 0 when empty.
- IO_BASE+4 `TONE`: read/write. Stores `data[7:0]`.

Decode rules:
- Addresses below IO_BASE go to RAM: `ram_wEn = wren & (address_dmem < IO_BASE)`.
- Addresses above IO_BASE+4 are unmapped: writes are ignored, reads return 0.
- Writes to read-only registers are ignored.

Side effects:
- Read side effects (pop, overflow clear) happen only at a posedge with `rden=1`, `wren=0` and a matching address. A stalled load that holds `rden` high for N cycles pops N entries, so the pipeline must drop `rden` while it is stalled.
- `wren` and `rden` both high: treat as a write and suppress read side effects.

Switch synchronizer:
- Two posedge flops: `SW` → `sw_m` → `sw_sync`.

Scancode FIFO (KEY_DEPTH entries, circular read/write pointers, separate count):
- Push on `key_valid` when not full.
- Push while full: scancode dropped, `overflow` set (sticky).
- Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
- Push and pop in the same cycle while empty: no pop happens, the push completes, and the read returns 0.
- Overflow set and KEY_STAT read in the same cycle: the set wins.
- Pointers wrap modulo KEY_DEPTH.

## Timing

- Read latency is 1 cycle. The data source select (RAM / IO register / zero) and the IO read value are registered at the posedge where the address is presented. `q_dmem` is valid for the following cycle:
  - RAM access: `q_dmem = ram_dataOut`.
  - IO access: `q_dmem` = the registered value.
- The KEY_DATA read value is the head entry before the pop.
- Write latency: LED and TONE take the new value at the posedge of the store; the outputs change right after that edge.
- SW latency is 2 cycles of synchronization plus 1 cycle of read latency.
- Reset values: `LED=0`, `tone=0`, `q_dmem=0`, registered select = zero source, `sw_m=sw_sync=0`, FIFO empty (pointers and count 0), `overflow=0`.
- Reset during an access aborts it. The next cycle returns 0 and there is no pop.

## Configuration

- Macro `MMIO_KEY_FIFO_EN`.
- Defined: the scancode FIFO is instantiated as described above.
- Undefined: no FIFO is built and `key_valid`/`key_code` are ignored.
  - KEY_STAT reads as `{..0, overflow=0, empty=1, count=0}`.
  - KEY_DATA reads 0 and has no side effects.
  - All other registers behave identically.

## Structure

- Package `mmio_pkg`:
  - Offsets `MMIO_SW=0`, `MMIO_LED=1`, `MMIO_KEY_STAT=2`, `MMIO_KEY_DATA=3`, `MMIO_TONE=4`, `MMIO_LAST=4`.
  - An enum type `mmio_sel_t` {SEL_RAM, SEL_IO, SEL_ZERO}.
- Sub-module `key_fifo`: parameterized by depth and width 8. Ports `push`, `din`, `pop`, `dout`, `count`, `empty`, `full`, `overflow`, `clr_ovf`. Instantiated only under `MMIO_KEY_FIFO_EN`.

## Test plan

- Store 0x0000A5A5 to 4097 → `LED=16'hA5A5` after that posedge. Load 4097 → `q_dmem=32'h0000A5A5` one cycle later. `ram_wEn` stays 0 throughout.
- Set `SW=16'h1234`, wait 2 cycles, load 4096 → `q_dmem=32'h00001234`. Store to 4096 → no change anywhere.
- Push 0x1C, 0x32 → KEY_STAT count=2, empty=0. Two single-cycle KEY_DATA loads → 0x1C, then 0x32. Third load → 0 and count stays 0.
- With KEY_DEPTH=8, push 9 codes → count=8, overflow=1. First KEY_STAT read shows overflow=1, the next shows 0. A push and a pop in the same cycle while full → count stays 8, overflow stays 0.
- Store 0xDEADBEEF to 100 → `ram_wEn=1`, `ram_addr=100`. Load 100 → `q_dmem` equals `ram_dataOut`. Load 5000 → `q_dmem=0`.
- Assert `reset` mid-load → `q_dmem=0`, LED=0, tone=0, FIFO empty next cycle. Build without `MMIO_KEY_FIFO_EN` → KEY_STAT reads 0x10 (empty bit set) regardless of `key_valid`.
